// File: rtl/parallel_macs_pkg.sv
// Shared constants and types for the parallel_macs multiply-accumulate datapath.
// Coefficients and accumulators are QW bits wide and wrap modulo 2^QW.
package parallel_macs_pkg;

    localparam int N       = 256;
    localparam int QW      = 13;
    localparam int SW      = 4;
    localparam int MAG_MAX = 5;

    typedef logic [QW-1:0] coeff_t;

    // Sign-magnitude secret coefficient: sign=1 means subtract.
    typedef struct packed {
        logic       sign;
        logic [2:0] mag;
    } secret_t;

endpackage

// File: rtl/parallel_macs_if.sv
// Bus bundle between the polynomial-multiplier controller (master) and the
// parallel_macs datapath (slave).
interface parallel_macs_if;
    import parallel_macs_pkg::*;

    // en is a one-cycle capture strobe with no backpressure. The datapath never
    // stalls, and valid is high exactly one cycle after en was sampled high.
    logic              en;
    logic [N*QW-1:0]   acc;
    logic [N*SW-1:0]   secret;
    coeff_t            a_coeff;
    coeff_t            a_mul_2;
    coeff_t            a_mul_3;
    coeff_t            a_mul_4;
    coeff_t            a_mul_5;
    logic [N*QW-1:0]   result;
    logic              valid;

    modport master (
        output en, acc, secret, a_coeff, a_mul_2, a_mul_3, a_mul_4, a_mul_5,
        input  result, valid
    );

    modport slave (
        input  en, acc, secret, a_coeff, a_mul_2, a_mul_3, a_mul_4, a_mul_5,
        output result, valid
    );

endinterface

// File: rtl/parallel_macs_mac_lane.sv
// One MAC lane: selects the multiple of a given by the secret magnitude, then
// adds it to or subtracts it from the accumulator slice, wrapping mod 2^QW.
module mac_lane
    import parallel_macs_pkg::*;
(
    input  coeff_t  acc_i,
    input  secret_t secret_i,
    input  coeff_t  a_i,
    input  coeff_t  a_mul_2_i,
    input  coeff_t  a_mul_3_i,
    input  coeff_t  a_mul_4_i,
    input  coeff_t  a_mul_5_i,
    output coeff_t  r_o
);

    coeff_t prod;

    // Magnitudes above MAG_MAX cannot occur in a valid secret; treat them as zero.
    always_comb begin
        prod = '0;
        case (secret_i.mag)
            3'd1:    prod = a_i;
            3'd2:    prod = a_mul_2_i;
            3'd3:    prod = a_mul_3_i;
            3'd4:    prod = a_mul_4_i;
            3'd5:    prod = a_mul_5_i;
            default: prod = '0;
        endcase
    end

    assign r_o = secret_i.sign ? (acc_i - prod) : (acc_i + prod);

endmodule

// File: rtl/parallel_macs.sv
// N-lane MAC datapath with a registered result and a 1-cycle valid.
// Build option PARALLEL_MACS_INTERNAL_MULT_EN derives 2a..5a internally instead of using the ports.
module parallel_macs
    import parallel_macs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    parallel_macs_if.slave  bus
);

    coeff_t          mul_2;
    coeff_t          mul_3;
    coeff_t          mul_4;
    coeff_t          mul_5;
    logic [N*QW-1:0] result_d;
    logic [N*QW-1:0] result_q;
    logic            valid_q;

`ifdef PARALLEL_MACS_INTERNAL_MULT_EN
    logic unused_mul_ports;

    // The caller's precomputed multiples are ignored in this build.
    assign unused_mul_ports = ^{bus.a_mul_2, bus.a_mul_3, bus.a_mul_4, bus.a_mul_5};
    assign mul_2 = {bus.a_coeff[QW-2:0], 1'b0};
    assign mul_3 = bus.a_coeff + mul_2;
    assign mul_4 = {bus.a_coeff[QW-3:0], 2'b00};
    assign mul_5 = bus.a_coeff + mul_4;
`else
    assign mul_2 = bus.a_mul_2;
    assign mul_3 = bus.a_mul_3;
    assign mul_4 = bus.a_mul_4;
    assign mul_5 = bus.a_mul_5;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        mac_lane u_lane (
            .acc_i     (bus.acc[i*QW +: QW]),
            .secret_i  (secret_t'(bus.secret[i*SW +: SW])),
            .a_i       (bus.a_coeff),
            .a_mul_2_i (mul_2),
            .a_mul_3_i (mul_3),
            .a_mul_4_i (mul_4),
            .a_mul_5_i (mul_5),
            .r_o       (result_d[i*QW +: QW])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                result_q <= result_d;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;

endmodule

// File: tb/tb_parallel_macs.sv
// Directed self-checking bench for parallel_macs; one task per scenario.
// Expected lane values are hand-computed tables and constants.
module tb_parallel_macs;
  import parallel_macs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  parallel_macs_if bus ();

  parallel_macs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic drive_acc_all(input logic [QW-1:0] v);
    for (int i = 0; i < N; i++) bus.acc[i*QW +: QW] = v;
  endtask

  task automatic drive_secret_all(input logic [SW-1:0] s);
    for (int i = 0; i < N; i++) bus.secret[i*SW +: SW] = s;
  endtask

  task automatic drive_a(input logic [QW-1:0] a, input logic [QW-1:0] m2,
                         input logic [QW-1:0] m3, input logic [QW-1:0] m4,
                         input logic [QW-1:0] m5);
    bus.a_coeff = a;
    bus.a_mul_2 = m2;
    bus.a_mul_3 = m3;
    bus.a_mul_4 = m4;
    bus.a_mul_5 = m5;
  endtask

  task automatic drive_random;
    for (int k = 0; k < (N*QW)/32; k++) bus.acc[k*32 +: 32] = $urandom;
    for (int k = 0; k < (N*SW)/32; k++) bus.secret[k*32 +: 32] = $urandom;
    drive_a(QW'($urandom_range(0, 8191)), QW'($urandom_range(0, 8191)),
            QW'($urandom_range(0, 8191)), QW'($urandom_range(0, 8191)),
            QW'($urandom_range(0, 8191)));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [QW-1:0] got;
    rst = 1'b0;
    bus.en = 1'b1;
    drive_random();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd0) begin
        n_err++; $display("FAIL reset_lane%0d: got %0d expected 0", i, got);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0;
    drive_random();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_valid: got %b expected 0", bus.valid);
    end
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd0) begin
        n_err++; $display("FAIL post_reset_lane%0d: got %0d expected 0", i, got);
      end
    end
  endtask

  task automatic test_positive;
    int exp_tab[6] = '{100, 107, 114, 121, 128, 135};
    logic [QW-1:0] got;
    @(negedge clk);
    drive_acc_all(13'd100);
    for (int i = 0; i < N; i++) bus.secret[i*SW +: SW] = SW'(i % 6);
    drive_a(13'd7, 13'd14, 13'd21, 13'd28, 13'd35);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.valid !== 1'b1) begin
      n_err++; $display("FAIL positive_valid: got %b expected 1", bus.valid);
    end
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== QW'(exp_tab[i % 6])) begin
        n_err++; $display("FAIL positive_lane%0d: got %0d expected %0d", i, got, exp_tab[i % 6]);
      end
    end
  endtask

  task automatic test_negative_mags;
    int exp_tab[6] = '{50, 43, 36, 29, 22, 15};
    logic [QW-1:0] got;
    @(negedge clk);
    drive_acc_all(13'd50);
    for (int i = 0; i < N; i++) bus.secret[i*SW +: SW] = SW'(8 + (i % 6));
    drive_a(13'd7, 13'd14, 13'd21, 13'd28, 13'd35);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== QW'(exp_tab[i % 6])) begin
        n_err++; $display("FAIL negative_lane%0d: got %0d expected %0d", i, got, exp_tab[i % 6]);
      end
    end
  endtask

  task automatic test_negative_wrap;
    logic [QW-1:0] got;
    @(negedge clk);
    drive_acc_all(13'd3);
    drive_secret_all(4'b1101);
    drive_a(13'd1, 13'd2, 13'd3, 13'd4, 13'd5);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'h1FFE) begin
        n_err++; $display("FAIL neg_wrap_lane%0d: got %0d expected 8190", i, got);
      end
    end
  endtask

  task automatic test_overflow_negzero;
    logic [QW-1:0] got;
    @(negedge clk);
    drive_acc_all(13'd8191);
    drive_secret_all(4'b0001);
    drive_a(13'd1, 13'd2, 13'd3, 13'd4, 13'd5);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd0) begin
        n_err++; $display("FAIL pos_wrap_lane%0d: got %0d expected 0", i, got);
      end
    end
    @(negedge clk);
    drive_secret_all(4'b1000);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd8191) begin
        n_err++; $display("FAIL neg_zero_lane%0d: got %0d expected 8191", i, got);
      end
    end
  endtask

  task automatic test_hold_mag67;
    logic [QW-1:0] got;
    logic [SW-1:0] s_tab[4] = '{4'h6, 4'h7, 4'hE, 4'hF};
    @(negedge clk);
    drive_acc_all(13'd1234);
    drive_secret_all(4'b0000);
    drive_a(13'd7, 13'd14, 13'd21, 13'd28, 13'd35);
    bus.en = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.en = 1'b0;
      drive_random();
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.valid !== 1'b0) begin
        n_err++; $display("FAIL hold_valid_c%0d: got %b expected 0", c, bus.valid);
      end
      for (int i = 0; i < N; i++) begin
        got = bus.result[i*QW +: QW];
        n_cmp++;
        if (got !== 13'd1234) begin
          n_err++; $display("FAIL hold_lane%0d_c%0d: got %0d expected 1234", i, c, got);
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.acc[i*QW +: QW] = QW'(i * 31);
      bus.secret[i*SW +: SW] = s_tab[i % 4];
    end
    drive_a(13'd7, 13'd14, 13'd21, 13'd28, 13'd35);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== QW'(i * 31)) begin
        n_err++; $display("FAIL mag67_lane%0d: got %0d expected %0d", i, got, i * 31);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [QW-1:0] got;
    @(negedge clk);
    drive_acc_all(13'd10);
    drive_secret_all(4'b0010);
    drive_a(13'd7, 13'd14, 13'd21, 13'd28, 13'd35);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd24) begin
        n_err++; $display("FAIL b2b_first_lane%0d: got %0d expected 24", i, got);
      end
    end
    @(negedge clk);
    drive_acc_all(13'd20);
    drive_secret_all(4'b1010);
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_valid: got %b expected 1", bus.valid);
    end
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd6) begin
        n_err++; $display("FAIL b2b_second_lane%0d: got %0d expected 6", i, got);
      end
    end
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_valid_drop: got %b expected 0", bus.valid);
    end
  endtask

  task automatic test_mid_reset;
    logic [QW-1:0] got;
    @(negedge clk);
    drive_acc_all(13'd500);
    drive_secret_all(4'b0001);
    drive_a(13'd7, 13'd14, 13'd21, 13'd28, 13'd35);
    bus.en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_valid: got %b expected 0", bus.valid);
    end
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd0) begin
        n_err++; $display("FAIL midrst_lane%0d: got %0d expected 0", i, got);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    drive_acc_all(13'd600);
    drive_secret_all(4'b0000);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== 13'd600) begin
        n_err++; $display("FAIL restart_lane%0d: got %0d expected 600", i, got);
      end
    end
  endtask

  task automatic test_internal_mult;
    logic [QW-1:0] got;
    logic [QW-1:0] exp;
`ifdef PARALLEL_MACS_INTERNAL_MULT_EN
    exp = 13'd808;
`else
    exp = 13'd4000;
`endif
    @(negedge clk);
    drive_acc_all(13'd4000);
    drive_secret_all(4'b0101);
    drive_a(13'd1000, 13'd0, 13'd0, 13'd0, 13'd0);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      got = bus.result[i*QW +: QW];
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL int_mult_lane%0d: got %0d expected %0d", i, got, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    bus.en = 1'b0;
    drive_acc_all(13'd0);
    drive_secret_all(4'b0000);
    drive_a(13'd0, 13'd0, 13'd0, 13'd0, 13'd0);
    test_reset();
    test_positive();
    test_negative_mags();
    test_negative_wrap();
    test_overflow_negzero();
    test_hold_mag67();
    test_back_to_back();
    test_mid_reset();
    test_internal_mult();
    @(negedge clk);
    bus.en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parallel_macs.md
Name: parallel_macs

Overview:
- Datapath core of the schoolbook polynomial multiplier: 256 parallel multiply-accumulate lanes, 13-bit coefficients modulo 2^13.
- Each lane adds or subtracts (small signed secret coefficient × a_coeff) to or from its accumulator slice.
- The controller broadcasts one public coefficient per step, shifts the secret polynomial, and writes `result` back into `acc`.
- Result is registered, with 1-cycle latency.

Parameters:
- N, 256, number of lanes/coefficients.
- QW, 13, coefficient and accumulator width (arithmetic mod 2^QW).
- SW, 4, secret coefficient width (sign-magnitude).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- en  input  1  capture enable; when 1, the result register loads the new MAC values.
- acc  input  N*QW (3328)  accumulator slices; lane i = acc[13i+12:13i].
- secret  input  N*SW (1024)  secret slices; lane i = secret[4i+3:4i]. Bit 3 is the sign (1 = negative); bits 2:0 are the magnitude.
- a_coeff  input  QW  broadcast public coefficient a.
- a_mul_2  input  QW  2a mod 2^13, precomputed by the caller.
- a_mul_3  input  QW  3a mod 2^13.
- a_mul_4  input  QW  4a mod 2^13.
- a_mul_5  input  QW  5a mod 2^13.
- result  output  N*QW  registered lane results, same slicing as acc.
- valid  output  1  high the cycle after en was sampled high.

Behaviour:
- Reset (rst=0, asynchronous): result=0 (all 3328 bits), valid=0.
- Per lane i, combinational:
  - mag = secret_i[2:0]; selected product p:
    - mag 0 -> 0
    - mag 1 -> a_coeff
    - mag 2 -> a_mul_2
    - mag 3 -> a_mul_3
    - mag 4 -> a_mul_4
    - mag 5 -> a_mul_5
    - mag 6,7 -> 0 (out of range, treated as zero)
  - sign=0: r_i = acc_i + p; sign=1: r_i = acc_i − p. Both are truncated to 13 bits (wrap mod 8192; no saturation).
  - Negative zero (secret 4'b1000) leaves acc_i unchanged.
- Clocked:
  - At posedge clk with en=1: result <= {r_255..r_0}; valid <= 1.
  - With en=0: result holds its value; valid <= 0.
- Latency: inputs sampled on edge k appear on result after edge k; a back-to-back en stream gives one result per cycle.
- Lanes are fully independent; no carry crosses slice boundaries.
- Multiples inputs are trusted. No internal consistency check unless the optional feature is enabled.
- Reset asserted mid-stream clears result immediately; accumulation restarts from the caller's acc.

Optional Feature:
- Macro PARALLEL_MACS_INTERNAL_MULT_EN.
- Defined: a_mul_2..a_mul_5 ports are ignored. Multiples are derived internally:
  - 2a = a<<1
  - 3a = a + (a<<1)
  - 4a = a<<2
  - 5a = a + (a<<2)
  - all truncated to 13 bits.
- Undefined: port values are used as given.
- The port list is identical in both builds.

Decomposition:
- Package parallel_macs_pkg holds:
  - constants N=256, QW=13, SW=4, MAG_MAX=5;
  - typedef coeff_t (13-bit);
  - typedef secret_t (4-bit: sign + 3-bit magnitude).
- One sub-module, mac_lane: combinational multiple-select plus add/sub for one lane. It is instantiated N times via generate.
- The result and valid registers live in parallel_macs.

Test Plan:
- Reset: hold rst=0 with random inputs -> result=0, valid=0. Release rst, en=0 -> result stays 0.
- Positive magnitudes, a_coeff=7, multiples 14/21/28/35, acc all 100, lane i secret = i mod 6 (sign 0), en=1 -> next cycle lane i = 100 + 7·(i mod 6). Lanes 0..5 = 100,107,114,121,128,135; valid=1.
- Negative with wrap: acc all 3, secret all 4'b1101 (−5), a_coeff=1, a_mul_5=5, en=1 -> every lane = 8190 (13'h1FFE).
- Positive overflow and negative zero: acc=8191, secret=4'b0001, a=1 -> 0. Separately, secret=4'b1000 -> acc unchanged (8191).
- Hold and magnitude 6/7: en=0 for 3 cycles with changing inputs -> result frozen, valid=0. Then en=1 with secret magnitudes 6 and 7 -> result equals acc.
- Optional macro build: a_coeff=1000, a_mul_* ports driven to 0, secret=4'b0101 -> lane = acc + 5000 mod 8192. Without the macro the same stimulus gives lane = acc.
